// File: rtl/des_pkg.sv
// Shared types and constants for the DES CBC/ECB block controller.
package des_pkg;

    localparam int DES_BLK_W  = 64;
    localparam int DES_KEY_W  = 64;
    localparam int DES_ROUNDS = 16;
    localparam int DES_TO_CYC = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } des_state_e;

    // Counter width able to hold the value cyc itself.
    function automatic int tmo_width(input int cyc);
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/des_tmo_cnt.sv
// Loadable watchdog counter: clear has priority over load, counting stops at LIMIT.
module des_tmo_cnt #(
    parameter int LIMIT = 32,
    parameter int W     = 6
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Clr,
    input  logic         i_En,
    input  logic         i_Load,
    input  logic [W-1:0] i_LoadVal,
    output logic         o_Exp
);

    logic [W-1:0] cnt_q, cnt_d;

    assign o_Exp = (cnt_q == W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (i_Clr)
            cnt_d = '0;
        else if (i_Load)
            cnt_d = i_LoadVal;
        else if (i_En && !o_Exp)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/des_cbc_ctrl.sv
// Block controller wrapping an iterative DES core; CBC chaining when
// DES_CBC_CHAIN_EN is defined, plain ECB otherwise.
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int TO_CYC = DES_TO_CYC
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    input  logic [DES_BLK_W-1:0] i_Data,
    input  logic                 i_fDec,
    input  logic                 i_fFirst,
    input  logic [DES_KEY_W-1:0] i_Key,
    input  logic [DES_BLK_W-1:0] i_IV,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic [DES_BLK_W-1:0] o_Data,
    output logic                 o_Err,
    output logic                 o_fStart,
    output logic                 o_fDec,
    output logic [DES_KEY_W-1:0] o_Key,
    output logic [DES_BLK_W-1:0] o_Text,
    input  logic                 i_fDone,
    input  logic [DES_BLK_W-1:0] i_Text
);

    localparam int TMO_W = tmo_width(TO_CYC);

    des_state_e           state_q, state_d;
    logic [DES_BLK_W-1:0] blk_q, blk_d;
    logic [DES_BLK_W-1:0] res_q, res_d;
    logic [DES_KEY_W-1:0] key_q, key_d;
    logic                 dec_q, dec_d;
    logic                 err_q, err_d;
    logic                 tmo_exp;

`ifdef DES_CBC_CHAIN_EN
    logic [DES_BLK_W-1:0] chain_q, chain_d;
`else
    logic unused_iv;
    assign unused_iv = ^i_IV;
`endif

    des_tmo_cnt #(
        .LIMIT (TO_CYC),
        .W     (TMO_W)
    ) u_tmo (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Clr     (state_q == ST_START),
        .i_En      (state_q == ST_WAIT),
        .i_Load    (1'b0),
        .i_LoadVal ('0),
        .o_Exp     (tmo_exp)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            res_q   <= '0;
            key_q   <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef DES_CBC_CHAIN_EN
            chain_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            res_q   <= res_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
`ifdef DES_CBC_CHAIN_EN
            chain_q <= chain_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        res_d   = res_q;
        key_d   = key_q;
        dec_d   = dec_q;
        err_d   = err_q;
`ifdef DES_CBC_CHAIN_EN
        chain_d = chain_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_Valid) begin
                    blk_d   = i_Data;
                    dec_d   = i_fDec;
                    state_d = ST_START;
                    if (i_fFirst) begin
                        key_d = i_Key;
`ifdef DES_CBC_CHAIN_EN
                        chain_d = i_IV;
`endif
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // A done pulse arriving in the expiry cycle still wins.
                if (i_fDone) begin
`ifdef DES_CBC_CHAIN_EN
                    res_d   = dec_q ? (i_Text ^ chain_q) : i_Text;
                    chain_d = dec_q ? blk_q : i_Text;
`else
                    res_d   = i_Text;
`endif
                    state_d = ST_OUT;
                end else if (tmo_exp) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (i_Ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_Ready  = (state_q == ST_IDLE) && !i_Rst;
        o_Valid  = 1'b0;
        o_Data   = '0;
        o_fStart = 1'b0;
        o_fDec   = 1'b0;
        o_Key    = '0;
        o_Text   = '0;
        // The timeout shows up in the expiry cycle itself, before the state drops to IDLE.
        o_Err    = err_q || ((state_q == ST_WAIT) && tmo_exp && !i_fDone);
        if (state_q == ST_START || state_q == ST_WAIT) begin
            o_fStart = (state_q == ST_START);
            o_fDec   = dec_q;
            o_Key    = key_q;
`ifdef DES_CBC_CHAIN_EN
            o_Text   = dec_q ? blk_q : (blk_q ^ chain_q);
`else
            o_Text   = blk_q;
`endif
        end
        if (state_q == ST_OUT) begin
            o_Valid = 1'b1;
            o_Data  = res_q;
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Directed bench for des_cbc_ctrl; the bench plays the DES core with canned results.
module tb_des_cbc_ctrl;

`ifdef DES_CBC_CHAIN_EN
    localparam bit CBC = 1'b1;
`else
    localparam bit CBC = 1'b0;
`endif
    localparam int TO = 32;
    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        i_Rst, i_Valid, i_fDec, i_fFirst, i_Ready, i_fDone;
    logic [63:0] i_Data, i_Key, i_IV, i_Text;
    logic        o_Ready, o_Valid, o_Err, o_fStart, o_fDec;
    logic [63:0] o_Data, o_Key, o_Text;

    int n_vec = 0;
    int n_err = 0;

    des_cbc_ctrl #(.TO_CYC(TO)) dut (
        .i_Clk(clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_Data(i_Data), .i_fDec(i_fDec), .i_fFirst(i_fFirst), .i_Key(i_Key),
        .i_IV(i_IV), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Data(o_Data),
        .o_Err(o_Err), .o_fStart(o_fStart), .o_fDec(o_fDec), .o_Key(o_Key),
        .o_Text(o_Text), .i_fDone(i_fDone), .i_Text(i_Text)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one block for a single cycle; returns in the START cycle (T+1).
    task automatic start_block(input logic [63:0] d, input logic dec, input logic first,
                               input logic [63:0] key, input logic [63:0] iv);
        i_Valid = 1'b1; i_Data = d; i_fDec = dec; i_fFirst = first; i_Key = key; i_IV = iv;
        tick();
        i_Valid = 1'b0; i_Data = ~d; i_fDec = ~dec; i_fFirst = 1'b0; i_Key = ~key; i_IV = ~iv;
    endtask

    // Core answers at T+18; returns in cycle T+19 with what was seen at T+18.
    task automatic finish_core(input logic [63:0] res, output logic v_early,
                               output logic [63:0] txt_late);
        repeat (17) tick();
        v_early  = o_Valid;
        txt_late = o_Text;
        i_fDone = 1'b1; i_Text = res;
        tick();
        i_fDone = 1'b0; i_Text = ~res;
    endtask

    task automatic release_out();
        i_Ready = 1'b1;
        tick();
        i_Ready = 1'b0;
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        tick();
        tick();
        n_vec++; if (o_Ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_low: got %b want 0", o_Ready); end
        n_vec++; if (o_Valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_Valid); end
        n_vec++; if (o_Err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", o_Err); end
        n_vec++; if (o_fStart !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", o_fStart); end
        n_vec++; if (o_Data !== 64'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", o_Data); end
        i_Rst = 1'b0;
        #1;
        n_vec++; if (o_Ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", o_Ready); end
        $display("reset done");
    endtask

    task automatic test_key_zero();
        logic v_early; logic [63:0] txt;
        start_block(PT, 1'b0, 1'b0, KEY, 64'hFFFF_FFFF_FFFF_FFFF);
        n_vec++; if (o_Key !== 64'h0) begin n_err++; $display("FAIL kz_key: got %h want 0", o_Key); end
        n_vec++; if (o_Text !== PT) begin n_err++; $display("FAIL kz_text: got %h want %h", o_Text, PT); end
        finish_core(64'h5555_5555_5555_5555, v_early, txt);
        n_vec++; if (o_Data !== 64'h5555_5555_5555_5555) begin n_err++; $display("FAIL kz_data: got %h want 5555555555555555", o_Data); end
        release_out();
        $display("block key_zero data=%h", PT);
    endtask

    task automatic test_enc_first();
        logic v_early; logic [63:0] txt;
        start_block(PT, 1'b0, 1'b1, KEY, 64'h0);
        n_vec++; if (o_fStart !== 1'b1) begin n_err++; $display("FAIL enc_start: got %b want 1", o_fStart); end
        n_vec++; if (o_Ready !== 1'b0) begin n_err++; $display("FAIL enc_ready: got %b want 0", o_Ready); end
        n_vec++; if (o_fDec !== 1'b0) begin n_err++; $display("FAIL enc_dir: got %b want 0", o_fDec); end
        n_vec++; if (o_Key !== KEY) begin n_err++; $display("FAIL enc_key: got %h want %h", o_Key, KEY); end
        n_vec++; if (o_Text !== PT) begin n_err++; $display("FAIL enc_text: got %h want %h", o_Text, PT); end
        tick();
        n_vec++; if (o_fStart !== 1'b0) begin n_err++; $display("FAIL enc_start_pulse: got %b want 0", o_fStart); end
        repeat (16) tick();
        v_early = o_Valid; txt = o_Text;
        n_vec++; if (v_early !== 1'b0) begin n_err++; $display("FAIL enc_valid_early: got %b want 0", v_early); end
        n_vec++; if (txt !== PT) begin n_err++; $display("FAIL enc_text_held: got %h want %h", txt, PT); end
        n_vec++; if (o_Key !== KEY) begin n_err++; $display("FAIL enc_key_held: got %h want %h", o_Key, KEY); end
        i_fDone = 1'b1; i_Text = CT;
        tick();
        i_fDone = 1'b0; i_Text = 64'h0;
        n_vec++; if (o_Valid !== 1'b1) begin n_err++; $display("FAIL enc_valid_t19: got %b want 1", o_Valid); end
        n_vec++; if (o_Data !== CT) begin n_err++; $display("FAIL enc_data: got %h want %h", o_Data, CT); end
        release_out();
        n_vec++; if (o_Valid !== 1'b0 || o_Ready !== 1'b1) begin n_err++; $display("FAIL enc_release: got valid=%b ready=%b want 0/1", o_Valid, o_Ready); end
        $display("block enc_first data=%h result=%h", PT, CT);
    endtask

    task automatic test_cbc_second();
        logic v_early; logic [63:0] txt; logic [63:0] want;
        want = CBC ? 64'h84CB563386A179EA : PT;
        start_block(PT, 1'b0, 1'b0, 64'h0, 64'h0);
        n_vec++; if (o_Text !== want) begin n_err++; $display("FAIL second_text: got %h want %h", o_Text, want); end
        n_vec++; if (o_Key !== KEY) begin n_err++; $display("FAIL second_key: got %h want %h", o_Key, KEY); end
        finish_core(64'hDEAD_BEEF_0011_2233, v_early, txt);
        n_vec++; if (txt !== want) begin n_err++; $display("FAIL second_text_held: got %h want %h", txt, want); end
        n_vec++; if (o_Data !== 64'hDEAD_BEEF_0011_2233) begin n_err++; $display("FAIL second_data: got %h want deadbeef00112233", o_Data); end
        release_out();
        $display("block cbc_second data=%h", PT);
    endtask

    task automatic test_dec();
        logic v_early; logic [63:0] txt; logic [63:0] want;
        start_block(CT, 1'b1, 1'b1, KEY, 64'h0);
        n_vec++; if (o_fDec !== 1'b1) begin n_err++; $display("FAIL dec_dir: got %b want 1", o_fDec); end
        n_vec++; if (o_Text !== CT) begin n_err++; $display("FAIL dec_text: got %h want %h", o_Text, CT); end
        finish_core(PT, v_early, txt);
        n_vec++; if (v_early !== 1'b0) begin n_err++; $display("FAIL dec_valid_early: got %b want 0", v_early); end
        n_vec++; if (o_Data !== PT) begin n_err++; $display("FAIL dec_data: got %h want %h", o_Data, PT); end
        release_out();
        // Chain now holds the ciphertext; the next decrypt shows it.
        want = CBC ? 64'hA7CA31762D289627 : 64'h2222_2222_2222_2222;
        start_block(64'h1111_1111_1111_1111, 1'b1, 1'b0, 64'h0, 64'h0);
        n_vec++; if (o_Text !== 64'h1111_1111_1111_1111) begin n_err++; $display("FAIL dec2_text: got %h want 1111111111111111", o_Text); end
        finish_core(64'h2222_2222_2222_2222, v_early, txt);
        n_vec++; if (o_Data !== want) begin n_err++; $display("FAIL dec2_data: got %h want %h", o_Data, want); end
        release_out();
        $display("block dec pair done");
    endtask

    task automatic test_iv_first();
        logic v_early; logic [63:0] txt; logic [63:0] want;
        want = CBC ? 64'hFEDC45677654CDEF : PT;
        start_block(PT, 1'b0, 1'b1, 64'hAAAA_5555_AAAA_5555, 64'hFFFF_0000_FFFF_0000);
        n_vec++; if (o_Text !== want) begin n_err++; $display("FAIL iv_text: got %h want %h", o_Text, want); end
        n_vec++; if (o_Key !== 64'hAAAA_5555_AAAA_5555) begin n_err++; $display("FAIL iv_key: got %h want aaaa5555aaaa5555", o_Key); end
        finish_core(64'h3333_3333_3333_3333, v_early, txt);
        n_vec++; if (o_Data !== 64'h3333_3333_3333_3333) begin n_err++; $display("FAIL iv_data: got %h want 3333333333333333", o_Data); end
        release_out();
        $display("block iv_first data=%h", PT);
    endtask

    task automatic test_stall();
        logic v_early; logic [63:0] txt; logic [63:0] want;
        want = CBC ? 64'h3333_3333_3333_3333 : 64'h0;
        start_block(64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        n_vec++; if (o_Text !== want) begin n_err++; $display("FAIL stall_text: got %h want %h", o_Text, want); end
        finish_core(64'h4444_4444_4444_4444, v_early, txt);
        for (int k = 0; k < 10; k++) begin
            n_vec++; if (o_Valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", k, o_Valid); end
            n_vec++; if (o_Data !== 64'h4444_4444_4444_4444) begin n_err++; $display("FAIL stall_data[%0d]: got %h want 4444444444444444", k, o_Data); end
            n_vec++; if (o_Ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", k, o_Ready); end
            tick();
        end
        release_out();
        n_vec++; if (o_Valid !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", o_Valid); end
        $display("block stall 10 cycles");
    endtask

    task automatic test_timeout();
        logic v_early; logic [63:0] txt; logic [63:0] want;
        want = CBC ? 64'h4444_4444_4444_4444 : 64'h0;
        start_block(64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        n_vec++; if (o_Text !== want) begin n_err++; $display("FAIL tmo_text: got %h want %h", o_Text, want); end
        tick();
        for (int k = 0; k <= TO; k++) begin
            n_vec++; if (o_Err !== (k == TO)) begin n_err++; $display("FAIL tmo_err[%0d]: got %b want %b", k, o_Err, k == TO); end
            n_vec++; if (o_Ready !== 1'b0 || o_Valid !== 1'b0) begin n_err++; $display("FAIL tmo_hs[%0d]: got ready=%b valid=%b want 0/0", k, o_Ready, o_Valid); end
            if (k < TO) tick();
        end
        tick();
        n_vec++; if (o_Ready !== 1'b1) begin n_err++; $display("FAIL tmo_ready_after: got %b want 1", o_Ready); end
        n_vec++; if (o_Err !== 1'b1 || o_Valid !== 1'b0) begin n_err++; $display("FAIL tmo_sticky: got err=%b valid=%b want 1/0", o_Err, o_Valid); end
        // Dropped block must leave the chain untouched.
        start_block(64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        n_vec++; if (o_Text !== want) begin n_err++; $display("FAIL tmo_chain_kept: got %h want %h", o_Text, want); end
        finish_core(64'h6666_6666_6666_6666, v_early, txt);
        n_vec++; if (o_Data !== 64'h6666_6666_6666_6666) begin n_err++; $display("FAIL tmo_next_data: got %h want 6666666666666666", o_Data); end
        n_vec++; if (o_Err !== 1'b1) begin n_err++; $display("FAIL tmo_err_kept: got %b want 1", o_Err); end
        release_out();
        $display("block timeout after %0d cycles", TO);
    endtask

    task automatic test_fdone_idle();
        i_fDone = 1'b1; i_Text = 64'h7777_7777_7777_7777;
        tick();
        i_fDone = 1'b0;
        tick();
        n_vec++; if (o_Valid !== 1'b0 || o_Ready !== 1'b1) begin n_err++; $display("FAIL done_idle: got valid=%b ready=%b want 0/1", o_Valid, o_Ready); end
        $display("stray done in idle");
    endtask

    task automatic test_reset_in_wait();
        start_block(64'h0, 1'b1, 1'b0, 64'h0, 64'h0);
        repeat (5) tick();
        i_Rst = 1'b1;
        tick();
        n_vec++; if (o_Ready !== 1'b0 || o_Valid !== 1'b0 || o_fStart !== 1'b0 || o_fDec !== 1'b0 || o_Err !== 1'b0) begin
            n_err++; $display("FAIL rw_flags: got ready=%b valid=%b start=%b dec=%b err=%b want all 0", o_Ready, o_Valid, o_fStart, o_fDec, o_Err); end
        n_vec++; if (o_Key !== 64'h0 || o_Text !== 64'h0 || o_Data !== 64'h0) begin
            n_err++; $display("FAIL rw_buses: got key=%h text=%h data=%h want 0", o_Key, o_Text, o_Data); end
        i_Rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            i_fDone = (k == 10);
            tick();
            n_vec++; if (o_Valid !== 1'b0) begin n_err++; $display("FAIL rw_late_valid[%0d]: got %b want 0", k, o_Valid); end
        end
        i_fDone = 1'b0;
        start_block(PT, 1'b0, 1'b0, KEY, 64'h0);
        n_vec++; if (o_Key !== 64'h0 || o_Text !== PT) begin n_err++; $display("FAIL rw_regs_cleared: got key=%h text=%h want 0/%h", o_Key, o_Text, PT); end
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        $display("reset in wait");
    endtask

    initial begin
        i_Rst = 1'b1; i_Valid = 1'b0; i_fDec = 1'b0; i_fFirst = 1'b0; i_Ready = 1'b0;
        i_fDone = 1'b0; i_Data = '0; i_Key = '0; i_IV = '0; i_Text = '0;
        test_reset();
        test_key_zero();
        test_enc_first();
        test_cbc_second();
        test_dec();
        test_iv_first();
        test_stall();
        test_timeout();
        test_fdone_idle();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
